// File: rtl/id_ex_stage.sv
// id_ex_stage: RV32I decode plus ID/EX pipeline register.
// Bypasses same-cycle WB writes, stalls on load-use, counts stalls.
module id_ex_stage #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             if_valid,
   input  logic [XLEN-1:0]  if_pc,
   input  logic [31:0]      if_inst,
   input  logic             flush,
   output logic [4:0]       rs1_index,
   output logic [4:0]       rs2_index,
   input  logic [XLEN-1:0]  rs1_data_in,
   input  logic [XLEN-1:0]  rs2_data_in,
   input  logic             wb_en,
   input  logic [4:0]       wb_rd,
   input  logic [XLEN-1:0]  wb_data,
   output logic             id_stall,
   output logic             ex_valid,
   output logic [XLEN-1:0]  ex_pc,
   output logic [XLEN-1:0]  ex_rs1_data,
   output logic [XLEN-1:0]  ex_rs2_data,
   output logic [XLEN-1:0]  ex_imm,
   output logic [4:0]       ex_rd,
   output logic [4:0]       ex_rs1,
   output logic [4:0]       ex_rs2,
   output logic [6:0]       ex_opcode,
   output logic [2:0]       ex_funct3,
   output logic             ex_funct7b5,
   output logic             ex_reg_write,
   output logic             ex_mem_read,
   output logic             ex_mem_write,
   output logic [CNT_W-1:0] stall_count
);

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] rs1_data;
      logic [XLEN-1:0] rs2_data;
      logic [XLEN-1:0] imm;
      logic [4:0]      rd;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [6:0]      opcode;
      logic [2:0]      funct3;
      logic            funct7b5;
      logic            reg_write;
      logic            mem_read;
      logic            mem_write;
   } id_ex_t;

   id_ex_t           r_ex;
   id_ex_t           w_dec;
   logic [CNT_W-1:0] r_stall_cnt;

   logic [6:0]  w_opc;
   logic [4:0]  w_rd;
   logic [4:0]  w_rs1;
   logic [4:0]  w_rs2;
   logic        w_lui, w_auipc, w_jal, w_jalr;
   logic        w_branch, w_load, w_store, w_opimm, w_op;
   logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
   logic [31:0] w_imm32;
   logic        w_uses_rs1, w_uses_rs2;
   logic        w_wr, w_ld, w_st;
   logic [XLEN-1:0] w_op1, w_op2;
   logic        w_load_use;

   assign w_opc = if_inst[6:0];
   assign w_rd  = if_inst[11:7];
   assign w_rs1 = if_inst[19:15];
   assign w_rs2 = if_inst[24:20];

   assign rs1_index = w_rs1;
   assign rs2_index = w_rs2;

   assign w_lui    = (w_opc == OP_LUI);
   assign w_auipc  = (w_opc == OP_AUIPC);
   assign w_jal    = (w_opc == OP_JAL);
   assign w_jalr   = (w_opc == OP_JALR);
   assign w_branch = (w_opc == OP_BRANCH);
   assign w_load   = (w_opc == OP_LOAD);
   assign w_store  = (w_opc == OP_STORE);
   assign w_opimm  = (w_opc == OP_IMM);
   assign w_op     = (w_opc == OP_OP);

   assign w_imm_i = {{20{if_inst[31]}}, if_inst[31:20]};
   assign w_imm_s = {{20{if_inst[31]}}, if_inst[31:25], if_inst[11:7]};
   assign w_imm_b = {{19{if_inst[31]}}, if_inst[31], if_inst[7],
                     if_inst[30:25], if_inst[11:8], 1'b0};
   assign w_imm_u = {if_inst[31:12], 12'b0};
   assign w_imm_j = {{11{if_inst[31]}}, if_inst[31], if_inst[19:12],
                     if_inst[20], if_inst[30:21], 1'b0};

   always_comb begin
      w_imm32    = '0;
      w_uses_rs1 = 1'b0;
      w_uses_rs2 = 1'b0;
      w_wr       = 1'b0;
      w_ld       = 1'b0;
      w_st       = 1'b0;
      unique case (1'b1)
         w_lui, w_auipc: begin
            w_imm32 = w_imm_u;
            w_wr    = 1'b1;
         end
         w_jal: begin
            w_imm32 = w_imm_j;
            w_wr    = 1'b1;
         end
         w_jalr, w_opimm: begin
            w_imm32    = w_imm_i;
            w_uses_rs1 = 1'b1;
            w_wr       = 1'b1;
         end
         w_load: begin
            w_imm32    = w_imm_i;
            w_uses_rs1 = 1'b1;
            w_wr       = 1'b1;
            w_ld       = 1'b1;
         end
         w_store: begin
            w_imm32    = w_imm_s;
            w_uses_rs1 = 1'b1;
            w_uses_rs2 = 1'b1;
            w_st       = 1'b1;
         end
         w_branch: begin
            w_imm32    = w_imm_b;
            w_uses_rs1 = 1'b1;
            w_uses_rs2 = 1'b1;
         end
         w_op: begin
            w_uses_rs1 = 1'b1;
            w_uses_rs2 = 1'b1;
            w_wr       = 1'b1;
         end
         default: ;
      endcase
   end

   // RF writes land at the edge, so a same-cycle WB write is bypassed here
   assign w_op1 = (w_rs1 == 5'd0) ? '0 :
                  (wb_en && wb_rd == w_rs1) ? wb_data : rs1_data_in;
   assign w_op2 = (w_rs2 == 5'd0) ? '0 :
                  (wb_en && wb_rd == w_rs2) ? wb_data : rs2_data_in;

   assign w_load_use = r_ex.valid && r_ex.mem_read &&
                       (r_ex.rd != 5'd0) && if_valid &&
                       ((w_uses_rs1 && r_ex.rd == w_rs1) ||
                        (w_uses_rs2 && r_ex.rd == w_rs2));

   assign id_stall = w_load_use && !flush;

   always_comb begin
      w_dec           = '0;
      w_dec.valid     = if_valid;
      w_dec.pc        = if_pc;
      w_dec.rs1_data  = w_op1;
      w_dec.rs2_data  = w_op2;
      w_dec.imm       = XLEN'($signed(w_imm32));
      w_dec.rd        = w_rd;
      w_dec.rs1       = w_rs1;
      w_dec.rs2       = w_rs2;
      w_dec.opcode    = w_opc;
      w_dec.funct3    = if_inst[14:12];
      w_dec.funct7b5  = if_inst[30];
      w_dec.reg_write = w_wr && (w_rd != 5'd0);
      w_dec.mem_read  = w_ld;
      w_dec.mem_write = w_st;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_ex <= '0;
      else if (flush || w_load_use)
         r_ex <= '0;
      else
         r_ex <= w_dec;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_stall_cnt <= '0;
      else if (id_stall && r_stall_cnt != '1)
         r_stall_cnt <= r_stall_cnt + 1'b1;
   end

   assign ex_valid     = r_ex.valid;
   assign ex_pc        = r_ex.pc;
   assign ex_rs1_data  = r_ex.rs1_data;
   assign ex_rs2_data  = r_ex.rs2_data;
   assign ex_imm       = r_ex.imm;
   assign ex_rd        = r_ex.rd;
   assign ex_rs1       = r_ex.rs1;
   assign ex_rs2       = r_ex.rs2;
   assign ex_opcode    = r_ex.opcode;
   assign ex_funct3    = r_ex.funct3;
   assign ex_funct7b5  = r_ex.funct7b5;
   assign ex_reg_write = r_ex.reg_write;
   assign ex_mem_read  = r_ex.mem_read;
   assign ex_mem_write = r_ex.mem_write;
   assign stall_count  = r_stall_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed and random checks of id_ex_stage
// against a per-instruction reference model.
module tb_id_ex_stage;

   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          if_valid;
   logic [31:0]   if_pc;
   logic [31:0]   if_inst;
   logic          flush;
   logic [4:0]    rs1_index, rs2_index;
   logic [31:0]   rs1_data_in, rs2_data_in;
   logic          wb_en;
   logic [4:0]    wb_rd;
   logic [31:0]   wb_data;
   logic          id_stall;
   logic          ex_valid;
   logic [31:0]   ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
   logic [4:0]    ex_rd, ex_rs1, ex_rs2;
   logic [6:0]    ex_opcode;
   logic [2:0]    ex_funct3;
   logic          ex_funct7b5, ex_reg_write, ex_mem_read, ex_mem_write;
   logic [CW-1:0] stall_count;

   id_ex_stage #(.XLEN(32), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
      .flush(flush),
      .rs1_index(rs1_index), .rs2_index(rs2_index),
      .rs1_data_in(rs1_data_in), .rs2_data_in(rs2_data_in),
      .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
      .id_stall(id_stall),
      .ex_valid(ex_valid), .ex_pc(ex_pc),
      .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
      .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
      .ex_opcode(ex_opcode), .ex_funct3(ex_funct3),
      .ex_funct7b5(ex_funct7b5), .ex_reg_write(ex_reg_write),
      .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc, rs1d, rs2d, imm;
      logic [4:0]  rd, rs1, rs2;
      logic [6:0]  opc;
      logic [2:0]  f3;
      logic        f7, wr, ld, st;
   } exp_t;

   exp_t          m;
   logic [CW-1:0] m_cnt;
   logic          e_stall;
   int            n_run = 0;
   int            n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] o,
                      input logic [31:0] e);
      n_run++;
      assert (o === e) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, o, e);
      end
   endtask

   function automatic void ref_dec(input logic [31:0] ins,
      output logic [31:0] imm, output logic u1, output logic u2,
      output logic wr, output logic ld, output logic st);
      logic signed [31:0] s, t;
      s = ins;
      imm = '0; u1 = 0; u2 = 0; wr = 0; ld = 0; st = 0;
      case (ins[6:0])
         7'h37, 7'h17: begin
            imm = ins & 32'hFFFFF000; wr = 1;
         end
         7'h6F: begin
            t = s >>> 11;
            imm = (t & ~32'hFFFFF) | (ins & 32'h000FF000) |
                  ({31'b0, ins[20]} << 11) | ({22'b0, ins[30:21]} << 1);
            wr = 1;
         end
         7'h67, 7'h13: begin
            t = s >>> 20; imm = t; u1 = 1; wr = 1;
         end
         7'h03: begin
            t = s >>> 20; imm = t; u1 = 1; wr = 1; ld = 1;
         end
         7'h23: begin
            t = s >>> 20;
            imm = (t & ~32'h1F) | {27'b0, ins[11:7]};
            u1 = 1; u2 = 1; st = 1;
         end
         7'h63: begin
            t = s >>> 19;
            imm = (t & ~32'hFFF) | ({31'b0, ins[7]} << 11) |
                  ({26'b0, ins[30:25]} << 5) | ({28'b0, ins[11:8]} << 1);
            u1 = 1; u2 = 1;
         end
         7'h33: begin
            u1 = 1; u2 = 1; wr = 1;
         end
         default: ;
      endcase
      if (ins[11:7] == 5'd0) wr = 0;
   endfunction

   function automatic logic [31:0] opnd(input logic [4:0] idx,
                                        input logic [31:0] rf);
      if (idx == 5'd0) return 32'd0;
      if (wb_en && wb_rd == idx) return wb_data;
      return rf;
   endfunction

   task automatic cmp_model();
      chk("ex_valid", ex_valid, m.valid);
      chk("ex_pc", ex_pc, m.pc);
      chk("ex_rs1_data", ex_rs1_data, m.rs1d);
      chk("ex_rs2_data", ex_rs2_data, m.rs2d);
      chk("ex_imm", ex_imm, m.imm);
      chk("ex_rd", ex_rd, m.rd);
      chk("ex_rs1", ex_rs1, m.rs1);
      chk("ex_rs2", ex_rs2, m.rs2);
      chk("ex_opcode", ex_opcode, m.opc);
      chk("ex_funct3", ex_funct3, m.f3);
      chk("ex_funct7b5", ex_funct7b5, m.f7);
      chk("ex_reg_write", ex_reg_write, m.wr);
      chk("ex_mem_read", ex_mem_read, m.ld);
      chk("ex_mem_write", ex_mem_write, m.st);
      chk("stall_count", stall_count, m_cnt);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_valid"}, ex_valid, 0);
      chk({tag, "_pc"}, ex_pc, 0);
      chk({tag, "_rs1d"}, ex_rs1_data, 0);
      chk({tag, "_rs2d"}, ex_rs2_data, 0);
      chk({tag, "_imm"}, ex_imm, 0);
      chk({tag, "_rd"}, ex_rd, 0);
      chk({tag, "_rs"}, {ex_rs1, ex_rs2}, 0);
      chk({tag, "_opc"}, {ex_opcode, ex_funct3, ex_funct7b5}, 0);
      chk({tag, "_ctl"}, {ex_reg_write, ex_mem_read, ex_mem_write}, 0);
      chk({tag, "_cnt"}, stall_count, 0);
      chk({tag, "_stall"}, id_stall, 0);
   endtask

   // Called at posedge+1 with inputs already applied; returns at next posedge+1.
   task automatic step();
      logic [31:0] imm;
      logic u1, u2, wr, ld, st, lu;
      exp_t nx;
      ref_dec(if_inst, imm, u1, u2, wr, ld, st);
      lu = m.valid && m.ld && (m.rd != 0) && if_valid &&
           ((u1 && m.rd == if_inst[19:15]) || (u2 && m.rd == if_inst[24:20]));
      e_stall = lu && !flush;
      nx = '0;
      nx.valid = if_valid;
      nx.pc    = if_pc;
      nx.rs1d  = opnd(if_inst[19:15], rs1_data_in);
      nx.rs2d  = opnd(if_inst[24:20], rs2_data_in);
      nx.imm   = imm;
      nx.rd    = if_inst[11:7];
      nx.rs1   = if_inst[19:15];
      nx.rs2   = if_inst[24:20];
      nx.opc   = if_inst[6:0];
      nx.f3    = if_inst[14:12];
      nx.f7    = if_inst[30];
      nx.wr    = wr;
      nx.ld    = ld;
      nx.st    = st;
      #2;
      chk("id_stall", id_stall, e_stall);
      chk("rs1_index", rs1_index, if_inst[19:15]);
      chk("rs2_index", rs2_index, if_inst[24:20]);
      @(posedge clk);
      if (flush || lu) m = '0;
      else m = nx;
      if (e_stall && m_cnt != '1) m_cnt = m_cnt + 1'b1;
      #1;
      cmp_model();
   endtask

   task automatic drive(input logic v, input logic [31:0] pc,
                        input logic [31:0] ins, input logic fl);
      if_valid = v; if_pc = pc; if_inst = ins; flush = fl;
      rs1_data_in = $urandom; rs2_data_in = $urandom;
   endtask

   localparam logic [31:0] I_ADDI = 32'hFFD00293;
   localparam logic [31:0] I_ADD7 = 32'h006303B3;
   localparam logic [31:0] I_ADD0 = 32'h000003B3;
   localparam logic [31:0] I_LW   = 32'h0000A403;
   localparam logic [31:0] I_ADD9 = 32'h002404B3;
   localparam logic [31:0] I_BEQ  = 32'hFE000CE3;

   logic [6:0] opcs [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h23,
                             7'h63, 7'h13, 7'h33, 7'h7F, 7'h0F};

   initial begin
      logic [31:0] ins;
      m = '0; m_cnt = '0; e_stall = 0;
      rst_n = 0; wb_en = 0; wb_rd = 0; wb_data = 0;
      drive(0, 0, 0, 0);
      #3;
      chk_zero("reset0");
      @(negedge clk); rst_n = 1;
      @(posedge clk); #1;

      drive(1, 32'h100, I_ADDI, 0);
      step();
      chk("addi_valid", ex_valid, 1);
      chk("addi_imm", ex_imm, 32'hFFFFFFFD);
      chk("addi_rd", ex_rd, 5);
      chk("addi_wr", ex_reg_write, 1);
      chk("addi_rs1d", ex_rs1_data, 0);

      drive(1, 32'h104, I_ADD7, 0);
      rs1_data_in = 32'hDEAD; rs2_data_in = 32'hBEEF;
      wb_en = 1; wb_rd = 6; wb_data = 32'h1234;
      step();
      chk("byp_rs1d", ex_rs1_data, 32'h1234);
      chk("byp_rs2d", ex_rs2_data, 32'h1234);

      drive(1, 32'h108, I_ADD0, 0);
      wb_rd = 0;
      step();
      chk("x0_rs1d", ex_rs1_data, 0);
      chk("x0_rs2d", ex_rs2_data, 0);
      wb_en = 0;

      drive(1, 32'h10C, I_LW, 0);
      step();
      drive(1, 32'h110, I_ADD9, 0);
      step();
      chk("lu_stall", e_stall, 1);
      chk("lu_bubble", ex_valid, 0);
      chk("lu_cnt", stall_count, 1);
      step();
      chk("lu_add_valid", ex_valid, 1);
      chk("lu_add_rd", ex_rd, 9);

      drive(1, 32'h114, I_LW, 0);
      step();
      drive(1, 32'h118, I_ADD9, 1);
      step();
      chk("fl_bubble", ex_valid, 0);
      chk("fl_cnt", stall_count, 1);

      drive(1, 32'h11C, I_BEQ, 0);
      step();
      chk("beq_imm", ex_imm, 32'hFFFFFFF8);
      chk("beq_wr", ex_reg_write, 0);

      for (int i = 0; i < 16; i++) begin
         drive(1, 32'h200, I_LW, 0);
         step();
         drive(1, 32'h204, I_ADD9, 0);
         step();
         step();
      end
      chk("sat_cnt", stall_count, 4'hF);

      for (int i = 0; i < 400; i++) begin
         if (!e_stall) begin
            ins = $urandom;
            ins[6:0]   = opcs[$urandom_range(0, 10)];
            ins[11:7]  = 5'($urandom_range(0, 3));
            ins[19:15] = 5'($urandom_range(0, 3));
            ins[24:20] = 5'($urandom_range(0, 3));
            drive($urandom_range(0, 5) != 0, $urandom, ins,
                  $urandom_range(0, 7) == 0);
         end else begin
            drive(if_valid, if_pc, if_inst, $urandom_range(0, 7) == 0);
         end
         wb_en   = $urandom_range(0, 1) == 1;
         wb_rd   = 5'($urandom_range(0, 3));
         wb_data = $urandom;
         step();
      end

      wb_en = 0;
      drive(1, 32'h300, I_LW, 0);
      step();
      drive(1, 32'h304, I_ADD9, 0);
      #3;
      rst_n = 0;
      #1;
      chk_zero("reset_mid");
      m = '0; m_cnt = '0; e_stall = 0;
      @(negedge clk); rst_n = 1;
      @(posedge clk); #1;
      drive(1, 32'h308, I_ADDI, 0);
      step();

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Instruction-decode stage plus ID/EX pipeline register of the 5-stage RV32I pipeline.
- Takes the IF/ID instruction and drives the register-file read indices.
- Merges register-file read data with a WB-stage bypass, because register-file writes land on the clock edge and are not visible to same-cycle reads.
- Generates the immediate, detects load-use hazards, and registers the decoded bundle for EX. Supports stall, flush and a saturating stall counter.

Parameters:
- XLEN, 32, datapath width.
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_valid  in  1  IF/ID slot holds a valid instruction.
- if_pc  in  XLEN  PC of the IF/ID instruction.
- if_inst  in  32  IF/ID instruction word.
- flush  in  1  branch/jump redirect from EX; kill the ID instruction.
- rs1_index  out  5  register-file read index 1 (= if_inst[19:15]).
- rs2_index  out  5  register-file read index 2 (= if_inst[24:20]).
- rs1_data_in  in  XLEN  register-file read data 1.
- rs2_data_in  in  XLEN  register-file read data 2.
- wb_en  in  1  WB write enable (same signal driving the register file).
- wb_rd  in  5  WB destination index.
- wb_data  in  XLEN  WB write data.
- id_stall  out  1  hold PC and IF/ID this cycle (combinational).
- ex_valid  out  1  ID/EX slot valid.
- ex_pc  out  XLEN  registered PC.
- ex_rs1_data  out  XLEN  registered operand 1.
- ex_rs2_data  out  XLEN  registered operand 2.
- ex_imm  out  XLEN  registered sign-extended immediate.
- ex_rd  out  5  registered destination index.
- ex_rs1  out  5  registered rs1 index, for EX forwarding.
- ex_rs2  out  5  registered rs2 index, for EX forwarding.
- ex_opcode  out  7  registered opcode.
- ex_funct3  out  3  registered funct3.
- ex_funct7b5  out  1  registered inst[30].
- ex_reg_write  out  1  registered: instruction writes rd.
- ex_mem_read  out  1  registered: instruction is a load.
- ex_mem_write  out  1  registered: instruction is a store.
- stall_count  out  CNT_W  load-use stall cycles since reset, saturating.

Behaviour:
- Reset (rst_n low, asynchronous): all ex_* outputs and stall_count go to 0. id_stall is combinational and evaluates to 0, because ex_valid is 0.
- Decode by opcode:
  - LUI/AUIPC: U-type immediate.
  - JAL: J-type immediate.
  - JALR, LOAD, OP-IMM: I-type immediate.
  - STORE: S-type immediate.
  - BRANCH: B-type immediate.
  - OP: immediate = 0.
- The immediate is sign-extended from inst[31]; B-type and J-type bit 0 is 0.
- uses_rs1: JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
- uses_rs2: BRANCH, STORE, OP.
- reg_write is 1 for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP, and is forced to 0 when rd = 0.
- Unsupported opcode: decoded as a NOP with reg_write, mem_read and mem_write all 0. ex_valid still follows if_valid.
- Operand select, per source:
  - index = 0 -> 0.
  - else wb_en && wb_rd == index -> wb_data (WB bypass).
  - else register-file data.
- load_use = ex_valid && ex_mem_read && ex_rd != 0 && if_valid && ((uses_rs1 && ex_rs1_idx_match) || (uses_rs2 && ex_rs2_idx_match)), where a match means ex_rd equals the corresponding ID source index.
- id_stall = load_use && !flush.
- Rising-edge update, first matching case wins:
  - flush: bubble (ex_valid = 0; reg_write, mem_read, mem_write = 0; other fields don't-care but held at 0).
  - load_use: bubble, and stall_count increments.
  - otherwise: load the decoded bundle with ex_valid = if_valid.
- Latency: one cycle, IF/ID to ID/EX.
- A load-use stall lasts exactly one cycle. The next cycle the load has left EX and load_use drops.
- stall_count saturates at all-ones and does not wrap.
- Flush and load_use in the same cycle: flush wins. id_stall = 0, bubble inserted, no count.
- When if_valid = 0, no hazard is raised and a bubble propagates.

Test Plan:
- Reset: assert rst_n = 0 mid-stream with ex_valid = 1 -> all ex_* and stall_count read 0 immediately, without waiting for a clock edge.
- ADDI x5,x0,-3 (0xFFD00293) at pc 0x100 -> next cycle: ex_valid = 1, ex_imm = 0xFFFFFFFD, ex_rd = 5, ex_reg_write = 1, ex_rs1_data = 0.
- WB bypass: wb_en = 1, wb_rd = 6, wb_data = 0x1234, rs1_data_in = 0xDEAD; ADD x7,x6,x6 -> ex_rs1_data = ex_rs2_data = 0x1234. Repeat with wb_rd = 0 and rs = x0 -> operands 0.
- Load-use: LW x8,0(x1) then ADD x9,x8,x2 -> one cycle with id_stall = 1 and ex_valid = 0, stall_count = 1; the ADD enters EX the following cycle.
- Flush priority: same load-use setup with flush = 1 -> id_stall = 0, bubble inserted, stall_count unchanged.
- B-type immediate: BEQ encoding imm = -8 (0xFE000CE3) -> ex_imm = 0xFFFFFFF8, ex_reg_write = 0.
